// File: rtl/clk_enable_scheduler.sv
// Per-channel clock-enable/phase generator with runtime divide ratios; outputs decode registered state only.
// Config on a running channel is held pending until its period boundary (cfg_ready low meanwhile); sync_req re-phases all channels.
module clk_enable_scheduler #(
  parameter int NUM_CH    = 4,
  parameter int DIV_W     = 16,
  parameter int RESET_DIV = 2,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic              cfg_en,
  output logic              cfg_err,
  input  logic              sync_req,
  output logic [NUM_CH-1:0] tick_out,
  output logic [NUM_CH-1:0] phase_out,
  output logic [NUM_CH-1:0] en_out
);

  logic [DIV_W-1:0]  r_cnt  [NUM_CH];
  logic [DIV_W-1:0]  r_div  [NUM_CH];
  logic [DIV_W-1:0]  r_pdiv [NUM_CH];
  logic [NUM_CH-1:0] r_en;
  logic [NUM_CH-1:0] r_pen;
  logic [NUM_CH-1:0] r_pend;
  logic              r_err;

  logic [NUM_CH-1:0] w_sel;
  logic [NUM_CH-1:0] w_wrap;
  logic [NUM_CH-1:0] w_phase;
  logic [NUM_CH-1:0] w_hit;
  logic [NUM_CH-1:0] w_apply_new;
  logic [NUM_CH-1:0] w_apply_pend;
  logic              w_xfer;
  logic              w_bad;

  // Out-of-range channel numbers select nothing, so they see ready=1 and are dropped.
  always_comb begin
    w_sel        = '0;
    w_wrap       = '0;
    w_phase      = '0;
    w_apply_new  = '0;
    w_apply_pend = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_sel[i]   = (cfg_ch == CH_W'(i));
      w_wrap[i]  = r_en[i] && (r_cnt[i] == r_div[i] - DIV_W'(1));
      w_phase[i] = r_en[i] && (r_cnt[i] >= (r_div[i] >> 1));
    end
    w_hit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_hit[i]        = w_sel[i] && w_xfer && !w_bad;
      w_apply_new[i]  = w_hit[i] && (sync_req || !r_en[i] || w_wrap[i]);
      w_apply_pend[i] = r_pend[i] && (sync_req || w_wrap[i]);
    end
  end

  assign cfg_ready = ~|(w_sel & r_pend);
  assign w_xfer    = cfg_valid && cfg_ready;
  assign w_bad     = cfg_en && (cfg_div < DIV_W'(2));

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_err  <= 1'b0;
      r_en   <= '0;
      r_pen  <= '0;
      r_pend <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_cnt[i]  <= '0;
        r_div[i]  <= DIV_W'(RESET_DIV);
        r_pdiv[i] <= DIV_W'(RESET_DIV);
      end
    end else begin
      r_err <= w_xfer && w_bad;
      for (int i = 0; i < NUM_CH; i++) begin
        if (sync_req || w_wrap[i] || !r_en[i])
          r_cnt[i] <= '0;
        else
          r_cnt[i] <= r_cnt[i] + DIV_W'(1);

        // A disable keeps the old ratio; cfg_div is meaningless when cfg_en is low.
        if (w_apply_new[i]) begin
          r_en[i] <= cfg_en;
          if (cfg_en)
            r_div[i] <= cfg_div;
        end else if (w_apply_pend[i]) begin
          r_en[i] <= r_pen[i];
          if (r_pen[i])
            r_div[i] <= r_pdiv[i];
        end

        if (w_apply_pend[i]) begin
          r_pend[i] <= 1'b0;
        end else if (w_hit[i] && !w_apply_new[i]) begin
          r_pend[i] <= 1'b1;
          r_pen[i]  <= cfg_en;
          r_pdiv[i] <= cfg_div;
        end
      end
    end
  end

  assign tick_out  = w_wrap;
  assign phase_out = w_phase;
  assign en_out    = r_en;
  assign cfg_err   = r_err;

endmodule

// File: tb/tb_clk_enable_scheduler.sv
// Directed self-checking bench for clk_enable_scheduler (NUM_CH=4, DIV_W=8).
module tb_clk_enable_scheduler;

  logic       clk_in;
  logic       rst_n;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_div;
  logic       cfg_en;
  logic       cfg_err;
  logic       sync_req;
  logic [3:0] tick_out;
  logic [3:0] phase_out;
  logic [3:0] en_out;

  int n_err;
  int n_checks;

  clk_enable_scheduler #(
    .NUM_CH(4),
    .DIV_W(8),
    .RESET_DIV(2)
  ) dut (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_ch   (cfg_ch),
    .cfg_div  (cfg_div),
    .cfg_en   (cfg_en),
    .cfg_err  (cfg_err),
    .sync_req (sync_req),
    .tick_out (tick_out),
    .phase_out(phase_out),
    .en_out   (en_out)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic nxt();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Holds the request until accepted; returns one cycle after the transfer edge.
  task automatic do_write(input int ch, input int dv, input bit en);
    int w;
    cfg_ch    = 2'(ch);
    cfg_div   = 8'(dv);
    cfg_en    = en;
    cfg_valid = 1'b1;
    w = 0;
    while (!cfg_ready && w < 50) begin
      nxt();
      w++;
    end
    if (w >= 50) begin
      n_checks++;
      n_err++;
      $error("FAIL wr_timeout: observed=stalled expected=accept ch=%0d", ch);
    end
    nxt();
    cfg_valid = 1'b0;
  endtask

  initial begin
    n_err     = 0;
    n_checks  = 0;
    rst_n     = 1'b0;
    cfg_valid = 1'b0;
    cfg_ch    = 2'd0;
    cfg_div   = 8'd0;
    cfg_en    = 1'b0;
    sync_req  = 1'b0;

    // Reset state
    #12;
    chk("rst_tick",  32'(tick_out),  32'h0);
    chk("rst_phase", 32'(phase_out), 32'h0);
    chk("rst_en",    32'(en_out),    32'h0);
    chk("rst_err",   32'(cfg_err),   32'h0);
    chk("rst_ready", 32'(cfg_ready), 32'h1);
    @(negedge clk_in);
    rst_n = 1'b1;
    nxt();
    chk("idle_tick", 32'(tick_out), 32'h0);

    // Enable ch0 div=4 from disabled: ticks at T+4, T+8; phase 0,0,1,1
    do_write(0, 4, 1);
    for (int k = 1; k <= 8; k++) begin
      chk("en0_tick",  32'(tick_out[0]),  32'((k % 4) == 0));
      chk("en0_phase", 32'(phase_out[0]), 32'(((k - 1) % 4) >= 2));
      chk("en0_en",    32'(en_out[0]),    32'h1);
      nxt();
    end

    // Rejected write (div=1, en=1): one-cycle error, channel keeps running
    do_write(0, 1, 1);
    chk("err_pulse",  32'(cfg_err),      32'h1);
    chk("err_tick",   32'(tick_out[0]),  32'h0);
    chk("err_phase",  32'(phase_out[0]), 32'h0);
    chk("err_ready",  32'(cfg_ready),    32'h1);
    nxt();
    chk("err_drop",   32'(cfg_err),      32'h0);
    chk("err_phase2", 32'(phase_out[0]), 32'h1);
    chk("err_en",     32'(en_out[0]),    32'h1);

    // Disable (div=0, en=0) lands at the period boundary, no error
    do_write(0, 0, 0);
    chk("dis_last_tick", 32'(tick_out[0]), 32'h1);
    chk("dis_en_hold",   32'(en_out[0]),   32'h1);
    chk("dis_pend",      32'(cfg_ready),   32'h0);
    chk("dis_noerr",     32'(cfg_err),     32'h0);
    nxt();
    chk("dis_en",    32'(en_out[0]),    32'h0);
    chk("dis_tick",  32'(tick_out[0]),  32'h0);
    chk("dis_phase", 32'(phase_out[0]), 32'h0);
    chk("dis_ready", 32'(cfg_ready),    32'h1);
    nxt();
    chk("dis_noerr2", 32'(cfg_err),     32'h0);
    chk("dis_tick2",  32'(tick_out[0]), 32'h0);

    // Glitch-free change on ch1: div=5 running, write div=3 at cnt=2
    do_write(1, 5, 1);
    chk("g_en", 32'(en_out[1]), 32'h1);
    nxt();
    nxt();
    do_write(1, 3, 1);
    chk("g_pend_ready", 32'(cfg_ready),   32'h0);
    chk("g_cnt3",       32'(tick_out[1]), 32'h0);
    cfg_div   = 8'd4;
    cfg_en    = 1'b1;
    cfg_valid = 1'b1;
    nxt();
    chk("g_old_tick",   32'(tick_out[1]), 32'h1);
    chk("g_stall",      32'(cfg_ready),   32'h0);
    nxt();
    chk("g_new_c0_t",   32'(tick_out[1]),  32'h0);
    chk("g_new_c0_p",   32'(phase_out[1]), 32'h0);
    chk("g_ready_back", 32'(cfg_ready),    32'h1);
    nxt();
    cfg_valid = 1'b0;
    chk("g_2nd_pend",   32'(cfg_ready),    32'h0);
    chk("g_new_c1_p",   32'(phase_out[1]), 32'h1);
    chk("g_new_c1_t",   32'(tick_out[1]),  32'h0);
    nxt();
    chk("g_new_tick",   32'(tick_out[1]),  32'h1);
    nxt();
    chk("g_d4_c0_t",    32'(tick_out[1]),  32'h0);
    chk("g_d4_ready",   32'(cfg_ready),    32'h1);
    nxt();
    chk("g_d4_c1_p",    32'(phase_out[1]), 32'h0);
    nxt();
    chk("g_d4_c2_p",    32'(phase_out[1]), 32'h1);
    chk("g_d4_c2_t",    32'(tick_out[1]),  32'h0);
    nxt();
    chk("g_d4_tick",    32'(tick_out[1]),  32'h1);

    // Wrap-cycle write on ch2: div=6, write div=2 in its tick cycle
    do_write(2, 6, 1);
    repeat (5) nxt();
    chk("w_tick6", 32'(tick_out[2]), 32'h1);
    cfg_ch    = 2'd2;
    cfg_div   = 8'd2;
    cfg_en    = 1'b1;
    cfg_valid = 1'b1;
    chk("w_ready", 32'(cfg_ready), 32'h1);
    nxt();
    cfg_valid = 1'b0;
    chk("w_nopend", 32'(cfg_ready),    32'h1);
    chk("w_c0_t",   32'(tick_out[2]),  32'h0);
    chk("w_c0_p",   32'(phase_out[2]), 32'h0);
    nxt();
    chk("w_tick_a", 32'(tick_out[2]),  32'h1);
    chk("w_c1_p",   32'(phase_out[2]), 32'h1);
    nxt();
    chk("w_c0b_t",  32'(tick_out[2]),  32'h0);
    nxt();
    chk("w_tick_b", 32'(tick_out[2]),  32'h1);

    // sync_req: ch0=3, ch1=4, ch2=2, ch3 div=9 with div=7 pending
    do_write(0, 3, 1);
    do_write(3, 9, 1);
    do_write(3, 7, 1);
    chk("s_pend", 32'(cfg_ready), 32'h0);
    sync_req = 1'b1;
    nxt();
    sync_req = 1'b0;
    chk("s_ready", 32'(cfg_ready), 32'h1);
    for (int k = 1; k <= 9; k++) begin
      chk("s_ticks", 32'(tick_out),
          32'({((k % 7) == 0), ((k % 2) == 0), ((k % 4) == 0), ((k % 3) == 0)}));
      nxt();
    end

    // Async reset mid-period with ch3 config pending
    do_write(3, 2, 1);
    chk("r_pend", 32'(cfg_ready), 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("r_tick",  32'(tick_out),  32'h0);
    chk("r_phase", 32'(phase_out), 32'h0);
    chk("r_en",    32'(en_out),    32'h0);
    chk("r_ready", 32'(cfg_ready), 32'h1);
    chk("r_err",   32'(cfg_err),   32'h0);
    nxt();
    nxt();
    @(negedge clk_in);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      nxt();
      chk("r_quiet_t", 32'(tick_out), 32'h0);
      chk("r_quiet_e", 32'(en_out),   32'h0);
    end

    // Full-range ratio N=255 on ch0
    do_write(0, 255, 1);
    repeat (126) nxt();
    chk("f_p127", 32'(phase_out[0]), 32'h0);
    chk("f_t127", 32'(tick_out[0]),  32'h0);
    nxt();
    chk("f_p128", 32'(phase_out[0]), 32'h1);
    repeat (126) nxt();
    chk("f_t254", 32'(tick_out[0]),  32'h0);
    nxt();
    chk("f_t255", 32'(tick_out[0]),  32'h1);
    chk("f_p255", 32'(phase_out[0]), 32'h1);
    nxt();
    chk("f_t256", 32'(tick_out[0]),  32'h0);
    chk("f_p256", 32'(phase_out[0]), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/clk_enable_scheduler.md
# clk_enable_scheduler

Generates NUM_CH independent clock-enable strobes and matching square-wave phase signals from one system clock. Each channel has a divide ratio that can be reprogrammed at runtime. It sequences and configures the per-channel divide counters, so downstream logic stays in the single `clk_in` domain and never uses derived clocks. Configuration changes on a running channel take effect only at that channel's period boundary, so strobes never glitch. A global sync re-phases all channels together.

## Interface
- `NUM_CH`, default 4: number of channels; minimum 1.
- `DIV_W`, default 16: width of the divide ratio; minimum 2.
- `RESET_DIV`, default 2: divide ratio loaded into every channel at reset; must be ≥ 2.
- `clk_in`, in, 1: system clock; all logic is on its rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `cfg_valid`, in, 1: config request valid.
- `cfg_ready`, out, 1: config request can be accepted for channel `cfg_ch`.
- `cfg_ch`, in, max(1,$clog2(NUM_CH)): target channel; values ≥ NUM_CH are accepted and discarded.
- `cfg_div`, in, DIV_W: new divide ratio N.
- `cfg_en`, in, 1: new enable state for the channel.
- `cfg_err`, out, 1: one-cycle pulse reporting a rejected config.
- `sync_req`, in, 1: single-cycle pulse that re-phases all channels.
- `tick_out`, out, NUM_CH: one-cycle enable strobe per channel period.
- `phase_out`, out, NUM_CH: per-channel square wave.
- `en_out`, out, NUM_CH: current active enable state of each channel.

## Operation
- **Per-channel state:** counter `cnt` (DIV_W bits), active divide `div`, active enable `en`, pending `{div, en}` register, and a `pend` flag.
- **Outputs:** `tick_out[i] = en && cnt == div-1`. `phase_out[i] = en && cnt >= (div>>1)`. Both are decoded only from registered state, with no path from any input. `en_out[i] = en`.
- **Running channel:** `cnt` counts 0 to div-1 and wraps to 0. A disabled channel holds `cnt` = 0.
- **Handshake:**
  - `cfg_ready = !pend[cfg_ch]`; it is 1 when `cfg_ch` ≥ NUM_CH.
  - A transfer occurs when `cfg_valid && cfg_ready` are both high at a rising edge.
  - The master holds its fields stable until the transfer occurs.
- **Rejection:** if `cfg_en` = 1 and `cfg_div` < 2, the request is discarded and `cfg_err` pulses high in the next cycle. When `cfg_en` = 0, `cfg_div` is ignored and no error is raised.
- **Transfer to a disabled channel:** applied immediately. The next cycle has `div` and `en` loaded and `cnt` = 0.
- **Transfer to an enabled channel:** stored as pending and `pend` is set. It is applied on the wrap edge, the edge after the cycle where `cnt == div-1`. That edge loads `div`/`en`, sets `cnt` = 0 and clears `pend`.
  - The last old-period tick is always emitted.
  - A disable request takes effect at that same boundary.
- **Transfer in the wrap cycle itself:** applied on that same wrap edge, bypassing `pend`.
- **sync_req:**
  - On the next edge, every channel's `cnt` is set to 0 and any pending config is applied immediately.
  - A transfer accepted in the same cycle as `sync_req` is also applied immediately.
  - Ticks visible during the `sync_req` cycle still occur, since they come from registered state.
- **Reset:** all `en` = 0, `div` = RESET_DIV, `cnt` = 0, `pend` = 0. Outputs at reset: `tick_out` = 0, `phase_out` = 0, `en_out` = 0, `cfg_err` = 0, `cfg_ready` = 1. Reset during operation aborts all pending configs.

## Timing
- **Enable latency:** a transfer at edge T to a disabled channel gives `cnt` = 0 at T+1 and the first tick in cycle T+N.
- **Steady state:** one tick every N cycles.
- **Duty:** `phase_out` is low for floor(N/2) cycles and high for ceil(N/2) cycles. The tick falls in the last high cycle.
- **Re-programming latency:** a ratio change on a running channel takes effect at most old-N cycles after the transfer.
- **cfg_ready recovery:** `cfg_ready` for a channel returns to 1 in the cycle after its pending config is applied.
- **cfg_err:** asserts exactly one cycle after the offending transfer.
- **Counter range:** the full DIV_W range is supported; N = 2^DIV_W−1 is legal, and the `cnt` compare is full width.

## Test plan
- **Enable from disabled:** after reset, write ch0 with div=4, en=1 → `tick_out[0]` at cycles T+4, T+8, …; `phase_out[0]` pattern 0,0,1,1.
- **Glitch-free change:** ch1 runs at div=5; write div=3 mid-period → the old period completes, the tick is at the old boundary, then ticks every 3 cycles. `cfg_ready` is 0 while pending; a second write stalls until the change is applied.
- **Wrap-cycle write:** ch2 runs at div=6; write div=2 exactly in its tick cycle → the next period is 2 cycles long and `pend` never sets.
- **Error path:** write div=1 with en=1 → `cfg_err` is high for one cycle and the channel's state is unchanged. Write div=0 with en=0 → the channel disables at its boundary and `cfg_err` stays 0.
- **sync_req:** channels at div=3, 4, 7 are free-running; pulse `sync_req` → all `cnt` = 0 next cycle, first ticks 3, 4 and 7 cycles later, and a simultaneous pending config is applied immediately.
- **Async reset:** assert `rst_n` = 0 mid-period with a config pending → all outputs are 0 and `cfg_ready` is 1 immediately. After release, no ticks occur until a channel is re-enabled.
